// File: rtl/dccm_banked_mem.sv
// N-bank word-interleaved DCCM: one write port through a 2-entry forwarding buffer, lo/hi read ports,
// post-reset zeroing. Define DCCM_BANKED_MEM_PARITY_EN to store and check one even-parity bit per word.
module dccm_banked_mem #(
    parameter int NUM_BANKS  = 4,
    parameter int ROWS       = 256,
    parameter int DATA_WIDTH = 39,
    localparam int ADDR_WIDTH = $clog2(NUM_BANKS * ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req_ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_lo_en,
    input  logic [ADDR_WIDTH-1:0] rd_lo_addr,
    input  logic                  rd_hi_en,
    input  logic [ADDR_WIDTH-1:0] rd_hi_addr,
    output logic                  rd_lo_valid,
    output logic [DATA_WIDTH-1:0] rd_lo_data,
    output logic                  rd_hi_valid,
    output logic [DATA_WIDTH-1:0] rd_hi_data,
    output logic                  init_done
`ifdef DCCM_BANKED_MEM_PARITY_EN
    ,
    output logic                  rd_lo_perr,
    output logic                  rd_hi_perr
`endif
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = $clog2(ROWS);
`ifdef DCCM_BANKED_MEM_PARITY_EN
    localparam int MEM_W  = DATA_WIDTH + 1;
`else
    localparam int MEM_W  = DATA_WIDTH;
`endif

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    function automatic logic [MEM_W-1:0] make_word(input logic [DATA_WIDTH-1:0] d);
`ifdef DCCM_BANKED_MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        return a[BANK_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:BANK_W];
    endfunction

    logic [MEM_W-1:0]      mem_q [NUM_BANKS][ROWS];

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      init_row_q, init_row_d;
    logic [1:0]            wb_cnt_q, wb_cnt_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q [2];
    logic [ADDR_WIDTH-1:0] wb_addr_d [2];
    logic [MEM_W-1:0]      wb_word_q [2];
    logic [MEM_W-1:0]      wb_word_d [2];
    logic                  hi_pending_q, hi_pending_d;
    logic [ADDR_WIDTH-1:0] hi_addr_q, hi_addr_d;
    logic                  hi_fwd_hit_q, hi_fwd_hit_d;
    logic [MEM_W-1:0]      hi_fwd_word_q, hi_fwd_word_d;
    logic                  rd_lo_valid_q, rd_lo_valid_d;
    logic                  rd_hi_valid_q, rd_hi_valid_d;
    logic [MEM_W-1:0]      rd_lo_word_q, rd_lo_word_d;
    logic [MEM_W-1:0]      rd_hi_word_q, rd_hi_word_d;

    logic                  lo_acc, hi_acc, wr_acc, hi_conflict, drain;
    logic                  lo_fwd_hit, hi_fwd_hit;
    logic [MEM_W-1:0]      lo_fwd_word, hi_fwd_word;
    logic [1:0]            wb_vld;
    logic [1:0]            cnt_after_drain;
    logic [NUM_BANKS-1:0]  bank_busy, mem_we;
    logic [ROW_W-1:0]      mem_wrow [NUM_BANKS];
    logic [MEM_W-1:0]      mem_wdata [NUM_BANKS];

    assign init_done = (state_q == ST_RUN);
    assign req_ready = init_done & ~hi_pending_q & (wb_cnt_q < 2'd2);

    // Request decode, forwarding lookup and bank arbitration (pending hi > lo > hi > drain)
    always_comb begin
        lo_acc      = rd_lo_en & req_ready;
        hi_acc      = rd_hi_en & req_ready;
        wr_acc      = wr_en & req_ready;
        hi_conflict = lo_acc & hi_acc & (bank_of(rd_lo_addr) == bank_of(rd_hi_addr))
                    & (row_of(rd_lo_addr) != row_of(rd_hi_addr));
        wb_vld      = {wb_cnt_q == 2'd2, wb_cnt_q != 2'd0};
        lo_fwd_hit  = 1'b0;
        lo_fwd_word = '0;
        hi_fwd_hit  = 1'b0;
        hi_fwd_word = '0;
        for (int i = 0; i < 2; i++) begin
            if (wb_vld[i] && wb_addr_q[i] == rd_lo_addr) begin
                lo_fwd_hit  = 1'b1;
                lo_fwd_word = wb_word_q[i];
            end
            if (wb_vld[i] && wb_addr_q[i] == rd_hi_addr) begin
                hi_fwd_hit  = 1'b1;
                hi_fwd_word = wb_word_q[i];
            end
        end
        bank_busy = '0;
        if (hi_pending_q) bank_busy[bank_of(hi_addr_q)] = 1'b1;
        if (lo_acc) bank_busy[bank_of(rd_lo_addr)] = 1'b1;
        if (hi_acc && !hi_conflict) bank_busy[bank_of(rd_hi_addr)] = 1'b1;
        drain = (state_q == ST_RUN) && wb_vld[0] && !bank_busy[bank_of(wb_addr_q[0])];
    end

    // A deferred hi read keeps the forwarding result seen at request time,
    // so a write accepted alongside it never leaks into its data.
    always_comb begin
        rd_lo_valid_d = lo_acc;
        rd_lo_word_d  = rd_lo_word_q;
        if (lo_acc)
            rd_lo_word_d = lo_fwd_hit ? lo_fwd_word : mem_q[bank_of(rd_lo_addr)][row_of(rd_lo_addr)];
        rd_hi_valid_d = hi_pending_q | (hi_acc & ~hi_conflict);
        rd_hi_word_d  = rd_hi_word_q;
        if (hi_pending_q)
            rd_hi_word_d = hi_fwd_hit_q ? hi_fwd_word_q : mem_q[bank_of(hi_addr_q)][row_of(hi_addr_q)];
        else if (hi_acc && !hi_conflict)
            rd_hi_word_d = hi_fwd_hit ? hi_fwd_word : mem_q[bank_of(rd_hi_addr)][row_of(rd_hi_addr)];
        hi_pending_d  = hi_conflict;
        hi_addr_d     = hi_conflict ? rd_hi_addr : hi_addr_q;
        hi_fwd_hit_d  = hi_conflict ? hi_fwd_hit : hi_fwd_hit_q;
        hi_fwd_word_d = hi_conflict ? hi_fwd_word : hi_fwd_word_q;
    end

    always_comb begin
        wb_addr_d       = wb_addr_q;
        wb_word_d       = wb_word_q;
        cnt_after_drain = wb_cnt_q;
        if (drain) begin
            wb_addr_d[0]    = wb_addr_q[1];
            wb_word_d[0]    = wb_word_q[1];
            cnt_after_drain = wb_cnt_q - 2'd1;
        end
        wb_cnt_d = cnt_after_drain;
        if (wr_acc) begin
            wb_addr_d[cnt_after_drain[0]] = wr_addr;
            wb_word_d[cnt_after_drain[0]] = make_word(wr_data);
            wb_cnt_d                      = cnt_after_drain + 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_row_d = init_row_q;
        mem_we     = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            mem_wrow[b]  = init_row_q;
            mem_wdata[b] = '0;
        end
        case (state_q)
            ST_INIT: begin
                mem_we     = '1;
                init_row_d = init_row_q + 1'b1;
                if (init_row_q == ROW_W'(ROWS - 1)) state_d = ST_RUN;
            end
            default: begin
                if (drain) begin
                    mem_we[bank_of(wb_addr_q[0])]    = 1'b1;
                    mem_wrow[bank_of(wb_addr_q[0])]  = row_of(wb_addr_q[0]);
                    mem_wdata[bank_of(wb_addr_q[0])] = wb_word_q[0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_row_q    <= '0;
            wb_cnt_q      <= '0;
            hi_pending_q  <= 1'b0;
            rd_lo_valid_q <= 1'b0;
            rd_hi_valid_q <= 1'b0;
            rd_lo_word_q  <= '0;
            rd_hi_word_q  <= '0;
        end else begin
            state_q       <= state_d;
            init_row_q    <= init_row_d;
            wb_cnt_q      <= wb_cnt_d;
            hi_pending_q  <= hi_pending_d;
            rd_lo_valid_q <= rd_lo_valid_d;
            rd_hi_valid_q <= rd_hi_valid_d;
            rd_lo_word_q  <= rd_lo_word_d;
            rd_hi_word_q  <= rd_hi_word_d;
        end
    end

    always_ff @(posedge clk) begin
        wb_addr_q     <= wb_addr_d;
        wb_word_q     <= wb_word_d;
        hi_addr_q     <= hi_addr_d;
        hi_fwd_hit_q  <= hi_fwd_hit_d;
        hi_fwd_word_q <= hi_fwd_word_d;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++)
            if (mem_we[b]) mem_q[b][mem_wrow[b]] <= mem_wdata[b];
    end

    assign rd_lo_valid = rd_lo_valid_q;
    assign rd_hi_valid = rd_hi_valid_q;
    assign rd_lo_data  = rd_lo_word_q[DATA_WIDTH-1:0];
    assign rd_hi_data  = rd_hi_word_q[DATA_WIDTH-1:0];
`ifdef DCCM_BANKED_MEM_PARITY_EN
    assign rd_lo_perr  = rd_lo_valid_q & (^rd_lo_word_q);
    assign rd_hi_perr  = rd_hi_valid_q & (^rd_hi_word_q);
`endif

endmodule

// File: tb/tb_dccm_banked_mem.sv
// Bench for dccm_banked_mem: an architectural memory model checked every cycle plus directed literal checks.
module tb_dccm_banked_mem;
    localparam int NUM_BANKS  = 4;
    localparam int ROWS       = 256;
    localparam int DATA_WIDTH = 39;
    localparam int ADDR_WIDTH = 10;
    localparam int DEPTH      = NUM_BANKS * ROWS;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  req_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_lo_en;
    logic [ADDR_WIDTH-1:0] rd_lo_addr;
    logic                  rd_hi_en;
    logic [ADDR_WIDTH-1:0] rd_hi_addr;
    logic                  rd_lo_valid;
    logic [DATA_WIDTH-1:0] rd_lo_data;
    logic                  rd_hi_valid;
    logic [DATA_WIDTH-1:0] rd_hi_data;
    logic                  init_done;
`ifdef DCCM_BANKED_MEM_PARITY_EN
    logic                  rd_lo_perr;
    logic                  rd_hi_perr;
`endif

    dccm_banked_mem dut (
        .clk(clk), .rst(rst), .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_lo_en(rd_lo_en), .rd_lo_addr(rd_lo_addr),
        .rd_hi_en(rd_hi_en), .rd_hi_addr(rd_hi_addr),
        .rd_lo_valid(rd_lo_valid), .rd_lo_data(rd_lo_data),
        .rd_hi_valid(rd_hi_valid), .rd_hi_data(rd_hi_data),
        .init_done(init_done)
`ifdef DCCM_BANKED_MEM_PARITY_EN
        , .rd_lo_perr(rd_lo_perr), .rd_hi_perr(rd_hi_perr)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural model: memory holds every accepted write immediately; the write
    // buffer is tracked only as a queue of addresses for occupancy and drain timing.
    logic [DATA_WIDTH-1:0] m_mem [DEPTH];
    int                    m_wbq [$];
    bit                    m_known = 1'b0;
    int                    m_init_left = 0;
    bit                    m_pend = 1'b0;
    int                    m_pend_bank = 0;
    logic [DATA_WIDTH-1:0] m_pend_val = '0;
    bit                    m_lo_v = 1'b0, m_hi_v = 1'b0;
    logic [DATA_WIDTH-1:0] m_lo_d = '0, m_hi_d = '0;

    always @(negedge clk) begin : model_cmp
        bit ready, nlo_v, nhi_v;
        bit [NUM_BANKS-1:0] busy;
        int la, ha, wa;
        ready = (m_init_left == 0) && !m_pend && (m_wbq.size() < 2);
        if (m_known) begin
            check("req_ready", 64'(req_ready), 64'(ready));
            check("init_done", 64'(init_done), 64'(m_init_left == 0));
            check("rd_lo_valid", 64'(rd_lo_valid), 64'(m_lo_v));
            check("rd_hi_valid", 64'(rd_hi_valid), 64'(m_hi_v));
            if (m_lo_v) check("rd_lo_data", 64'(rd_lo_data), 64'(m_lo_d));
            if (m_hi_v) check("rd_hi_data", 64'(rd_hi_data), 64'(m_hi_d));
        end
        if (rst) begin
            m_known     = 1'b1;
            m_init_left = ROWS;
            m_pend      = 1'b0;
            m_wbq.delete();
            m_lo_v      = 1'b0;
            m_hi_v      = 1'b0;
            m_lo_d      = '0;
            m_hi_d      = '0;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else if (m_known) begin
            la = int'(rd_lo_addr);
            ha = int'(rd_hi_addr);
            wa = int'(wr_addr);
            busy  = '0;
            nlo_v = 1'b0;
            nhi_v = 1'b0;
            if (m_pend) begin
                nhi_v  = 1'b1;
                m_hi_d = m_pend_val;
                busy[m_pend_bank] = 1'b1;
                m_pend = 1'b0;
            end
            if (ready && rd_lo_en) begin
                nlo_v  = 1'b1;
                m_lo_d = m_mem[la];
                busy[la % NUM_BANKS] = 1'b1;
            end
            if (ready && rd_hi_en) begin
                if (rd_lo_en && (la % NUM_BANKS == ha % NUM_BANKS) && (la / NUM_BANKS != ha / NUM_BANKS)) begin
                    m_pend      = 1'b1;
                    m_pend_bank = ha % NUM_BANKS;
                    m_pend_val  = m_mem[ha];
                end else begin
                    nhi_v  = 1'b1;
                    m_hi_d = m_mem[ha];
                    busy[ha % NUM_BANKS] = 1'b1;
                end
            end
            if (m_init_left == 0 && m_wbq.size() > 0 && !busy[m_wbq[0] % NUM_BANKS])
                void'(m_wbq.pop_front());
            if (ready && wr_en) begin
                m_wbq.push_back(wa);
                m_mem[wa] = wr_data;
            end
            if (m_init_left > 0) m_init_left--;
            m_lo_v = nlo_v;
            m_hi_v = nhi_v;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit we, input int wa, input longint wd,
                         input bit le, input int la, input bit he, input int ha);
        wr_en      = we;
        wr_addr    = ADDR_WIDTH'(wa);
        wr_data    = DATA_WIDTH'(wd);
        rd_lo_en   = le;
        rd_lo_addr = ADDR_WIDTH'(la);
        rd_hi_en   = he;
        rd_hi_addr = ADDR_WIDTH'(ha);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 400) begin
            n++;
            tick();
        end
        check(name, 64'(n), 64'(ROWS));
        check({name, "_done"}, 64'(init_done), 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        idle();
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_lo_data", 64'(rd_lo_data), 64'd0);
        check("rst_hi_valid", 64'(rd_hi_valid), 64'd0);
        rst = 1'b0;

        // Zeroing window, then a read of the last address
        wait_init("init_cycles");
        drive(0, 0, 0, 1, 'h3FF, 0, 0); tick(); idle();
        check("t1_lo_valid", 64'(rd_lo_valid), 64'd1);
        check("t1_lo_data", 64'(rd_lo_data), 64'd0);

        drive(1, 5, 'h12345, 0, 0, 0, 0); tick(); idle(); tick(); tick();
        drive(0, 0, 0, 1, 5, 0, 0); tick(); idle();
        check("t2_lo_valid", 64'(rd_lo_valid), 64'd1);
        check("t2_lo_data", 64'(rd_lo_data), 64'h12345);
        tick();
        check("t2_lo_pulse", 64'(rd_lo_valid), 64'd0);
        drive(0, 0, 0, 1, 5, 1, 5); tick(); idle();
        check("t2_same_row_hi_valid", 64'(rd_hi_valid), 64'd1);
        check("t2_same_row_hi_data", 64'(rd_hi_data), 64'h12345);

        // Bank conflict: lo 4 / hi 8 both bank 0
        drive(1, 4, 'h111, 0, 0, 0, 0); tick();
        drive(1, 8, 'h222, 0, 0, 0, 0); tick(); idle(); tick(); tick();
        drive(0, 0, 0, 1, 4, 1, 8); tick(); idle();
        check("t3_lo_valid", 64'(rd_lo_valid), 64'd1);
        check("t3_lo_data", 64'(rd_lo_data), 64'h111);
        check("t3_hi_early", 64'(rd_hi_valid), 64'd0);
        check("t3_ready_low", 64'(req_ready), 64'd0);
        tick();
        check("t3_hi_valid", 64'(rd_hi_valid), 64'd1);
        check("t3_hi_data", 64'(rd_hi_data), 64'h222);
        check("t3_ready_back", 64'(req_ready), 64'd1);
        tick(); tick();

        // Forwarding while lo reads keep bank 3 busy
        drive(1, 7, 'hAAAA, 1, 7, 0, 0); tick();
        check("t4_same_cycle_old", 64'(rd_lo_data), 64'd0);
        drive(0, 0, 0, 1, 7, 0, 0); tick();
        check("t4_fwd_lo", 64'(rd_lo_data), 64'hAAAA);
        drive(0, 0, 0, 1, 11, 1, 7); tick(); idle();
        check("t4_lo_11", 64'(rd_lo_data), 64'd0);
        tick();
        check("t4_fwd_pending_hi", 64'(rd_hi_data), 64'hAAAA);
        tick(); tick();

        // Fill the buffer while bank 1 is hammered
        drive(1, 1, 'h5151, 1, 9, 0, 0); tick();
        drive(1, 5, 'h5555, 1, 9, 0, 0); tick(); idle();
        check("t5_full_ready", 64'(req_ready), 64'd0);
        tick(); tick();
        check("t5_drained_ready", 64'(req_ready), 64'd1);
        drive(0, 0, 0, 1, 1, 0, 0); tick();
        check("t5_rd1", 64'(rd_lo_data), 64'h5151);
        drive(0, 0, 0, 1, 5, 0, 0); tick(); idle();
        check("t5_rd5", 64'(rd_lo_data), 64'h5555);
        tick(); tick();

        // Reset with a full buffer and a pending hi read
        drive(1, 1, 'h6161, 1, 9, 0, 0); tick();
        drive(1, 13, 'h6666, 1, 17, 1, 21); tick(); idle();
        check("t6_ready_low", 64'(req_ready), 64'd0);
        rst = 1'b1; tick();
        check("t6_hi_valid", 64'(rd_hi_valid), 64'd0);
        check("t6_lo_valid", 64'(rd_lo_valid), 64'd0);
        check("t6_ready", 64'(req_ready), 64'd0);
        check("t6_init_done", 64'(init_done), 64'd0);
        rst = 1'b0;
        wait_init("t6_init_cycles");
        drive(0, 0, 0, 1, 1, 0, 0); tick();
        check("t6_rd1_zero", 64'(rd_lo_data), 64'd0);
        drive(0, 0, 0, 1, 13, 0, 0); tick(); idle();
        check("t6_rd13_zero", 64'(rd_lo_data), 64'd0);
        tick();

`ifdef DCCM_BANKED_MEM_PARITY_EN
        dut.mem_q[2][0][0] = ~dut.mem_q[2][0][0];
        m_mem[2] = m_mem[2] ^ DATA_WIDTH'(1);
        drive(0, 0, 0, 1, 2, 0, 0); tick(); idle();
        check("t6_perr_valid", 64'(rd_lo_valid), 64'd1);
        check("t6_perr", 64'(rd_lo_perr), 64'd1);
        tick();
`endif

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
